rs232_cmd_ctrl: RTL and testbench

RS232_CMD_CTRL -- requirements
Module: rs232_cmd_ctrl

---
 rtl/rs232_pkg.sv | 28 ++
 rtl/rs232_cmd_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rs232_cmd_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared types and codes for the RS232 command controller.
// The checksum helper takes an explicit enable so that callers decide
// (via RS232_CMD_CHKSUM_EN) whether a trailing checksum byte is part of the frame.
package rs232_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StExec,
    StRdWait,
    StResp,
    StErr
  } state_e;

  localparam logic [7:0] CmdWrite = 8'h57;  // 'W'
  localparam logic [7:0] CmdRead  = 8'h52;  // 'R'
  localparam logic [7:0] RespOk   = 8'h4B;  // 'K'
  localparam logic [7:0] RespErr  = 8'h45;  // 'E'

  // Byte index of the final frame byte for a given command.
  function automatic logic [1:0] frame_last_idx(input logic [7:0] cmd, input logic chk_en);
    logic [1:0] base;
    base = (cmd == CmdWrite) ? 2'd2 : 2'd1;
    return base + {1'b0, chk_en};
  endfunction

endpackage

// File: rtl/rs232_cmd_ctrl.sv
// Command controller between the RS232 RX FIFO and TX FIFO.
// Decodes 'W' addr data / 'R' addr frames, drives a simple register bus and
// returns one response byte per frame. Define RS232_CMD_CHKSUM_EN to require a
// trailing XOR checksum byte on every frame.
module rs232_cmd_ctrl
  import rs232_pkg::*;
#(
  parameter int unsigned P_TIMEOUT_CYCLES = 137500,
  parameter int unsigned P_ADDR_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                rx_fifo_rd_en,
  input  logic [7:0]          rx_fifo_dout,
  input  logic                rx_fifo_empty,
  output logic                tx_fifo_wr_en,
  output logic [7:0]          tx_fifo_data,
  input  logic                tx_fifo_full,
  output logic                reg_wr_en,
  output logic                reg_rd_en,
  output logic [P_ADDR_W-1:0] reg_addr,
  output logic [7:0]          reg_wdata,
  input  logic [7:0]          reg_rdata,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  localparam int unsigned CntW = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(P_TIMEOUT_CYCLES);

`ifdef RS232_CMD_CHKSUM_EN
  localparam logic ChkEn = 1'b1;
`else
  localparam logic ChkEn = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [P_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
`ifdef RS232_CMD_CHKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  logic       timeout_hit;
  logic       cmd_valid;
  logic [1:0] last_idx;

  // Timeout only arms once a frame has started (byte index past the command).
  assign timeout_hit = (idx_q != 2'd0) && (cnt_q == CntMax);
  assign cmd_valid   = (rx_fifo_dout == CmdWrite) || (rx_fifo_dout == CmdRead);
  assign last_idx    = frame_last_idx(cmd_q, ChkEn);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      cmd_q     <= 8'h00;
      addr_q    <= '0;
      data_q    <= 8'h00;
      tx_data_q <= 8'h00;
      err_cnt_q <= 8'h00;
      cnt_q     <= '0;
`ifdef RS232_CMD_CHKSUM_EN
      chk_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_data_q <= tx_data_d;
      err_cnt_q <= err_cnt_d;
      cnt_q     <= cnt_d;
`ifdef RS232_CMD_CHKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  // Inter-byte timeout: counts while waiting for a mid-frame byte, saturates at max.
  always_comb begin
    cnt_d = '0;
    if (state_q == StFetch && idx_q != 2'd0) begin
      cnt_d = timeout_hit ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Next-state, field capture and strobe generation.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    data_d        = data_q;
    tx_data_d     = tx_data_q;
    err_cnt_d     = err_cnt_q;
`ifdef RS232_CMD_CHKSUM_EN
    chk_d         = chk_q;
`endif
    rx_fifo_rd_en = 1'b0;
    tx_fifo_wr_en = 1'b0;
    reg_wr_en     = 1'b0;
    reg_rd_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        idx_d = 2'd0;
`ifdef RS232_CMD_CHKSUM_EN
        chk_d = 8'h00;
`endif
        if (!rx_fifo_empty) state_d = StFetch;
      end

      StFetch: begin
        if (timeout_hit) begin
          state_d   = StErr;
          tx_data_d = RespErr;
        end else if (!rx_fifo_empty) begin
          rx_fifo_rd_en = 1'b1;
          state_d       = StCapture;
        end
      end

      StCapture: begin
`ifdef RS232_CMD_CHKSUM_EN
        chk_d = chk_q ^ rx_fifo_dout;
`endif
        unique case (idx_q)
          2'd0:    cmd_d  = rx_fifo_dout;
          2'd1:    addr_d = rx_fifo_dout[P_ADDR_W-1:0];
          2'd2:    if (cmd_q == CmdWrite) data_d = rx_fifo_dout;
          default: ;
        endcase

        if (idx_q == 2'd0) begin
          if (!cmd_valid) begin
            state_d   = StErr;
            tx_data_d = RespErr;
          end else begin
            idx_d   = 2'd1;
            state_d = StFetch;
          end
        end else if (idx_q == last_idx) begin
`ifdef RS232_CMD_CHKSUM_EN
          // chk_q holds the XOR of every byte before this one.
          if (chk_q != rx_fifo_dout) begin
            state_d   = StErr;
            tx_data_d = RespErr;
          end else begin
            state_d = StExec;
          end
`else
          state_d = StExec;
`endif
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StFetch;
        end
      end

      StExec: begin
        if (cmd_q == CmdWrite) begin
          reg_wr_en = 1'b1;
          tx_data_d = RespOk;
          state_d   = StResp;
        end else begin
          reg_rd_en = 1'b1;
          state_d   = StRdWait;
        end
      end

      StRdWait: begin
        tx_data_d = reg_rdata;
        state_d   = StResp;
      end

      StResp: begin
        if (!tx_fifo_full) begin
          tx_fifo_wr_en = 1'b1;
          state_d       = StIdle;
        end
      end

      StErr: begin
        if (!tx_fifo_full) begin
          tx_fifo_wr_en = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign tx_fifo_data = tx_data_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = data_q;
  assign busy         = (state_q != StIdle);
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_rs232_cmd_ctrl.sv
// Scoreboard bench for rs232_cmd_ctrl: expected register accesses, response bytes
// and latencies are queued as frames are pushed, then popped as the DUT acts.
module tb_rs232_cmd_ctrl;

  localparam int unsigned TimeoutCycles = 300;
  localparam logic [7:0] W = 8'h57;
  localparam logic [7:0] R = 8'h52;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_fifo_rd_en;
  logic [7:0] rx_fifo_dout;
  logic       rx_fifo_empty;
  logic       tx_fifo_wr_en;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_full;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] err_cnt;

  rs232_cmd_ctrl #(
    .P_TIMEOUT_CYCLES(TimeoutCycles),
    .P_ADDR_W        (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_fifo_rd_en(rx_fifo_rd_en),
    .rx_fifo_dout (rx_fifo_dout),
    .rx_fifo_empty(rx_fifo_empty),
    .tx_fifo_wr_en(tx_fifo_wr_en),
    .tx_fifo_data (tx_fifo_data),
    .tx_fifo_full (tx_fifo_full),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .busy         (busy),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RX FIFO model: standard (non-FWFT) read, data valid the cycle after rd_en.
  logic [7:0] rx_mem [0:1023];
  int rx_wr_cnt = 0;
  int rx_rd_cnt = 0;
  assign rx_fifo_empty = (rx_rd_cnt == rx_wr_cnt);

  always @(posedge clk) begin
    if (rx_fifo_rd_en && (rx_rd_cnt != rx_wr_cnt)) begin
      rx_fifo_dout <= rx_mem[rx_rd_cnt];
      rx_rd_cnt    <= rx_rd_cnt + 1;
    end
  end

  // Scoreboards.
  logic [15:0] wrq[$];
  logic [7:0]  rdq[$];
  logic [7:0]  txq[$];
  int          latq[$];
  int          exp_err = 0;

  int cyc = 0;
  int last_rd = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [15:0] e;
    int l;
    cyc++;
    if (rx_fifo_rd_en) begin
      last_rd = cyc;
      check("rd_not_empty", rx_fifo_empty, 0);
    end
    if (reg_wr_en) begin
      check("wr_expected", wrq.size() != 0, 1);
      if (wrq.size() != 0) begin
        e = wrq.pop_front();
        check("wr_addr", reg_addr, e[15:8]);
        check("wr_data", reg_wdata, e[7:0]);
      end
    end
    if (reg_rd_en) begin
      check("rd_expected", rdq.size() != 0, 1);
      if (rdq.size() != 0) check("rd_addr", reg_addr, rdq.pop_front());
    end
    if (tx_fifo_wr_en) begin
      check("tx_not_full", tx_fifo_full, 0);
      check("tx_expected", txq.size() != 0, 1);
      if (txq.size() != 0) begin
        check("tx_byte", tx_fifo_data, txq.pop_front());
        l = latq.pop_front();
        if (l >= 0) check("latency", cyc - last_rd, l);
      end
    end
  end

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr_cnt] = b;
    rx_wr_cnt++;
  endtask

  task automatic send_write(input logic [7:0] a, input logic [7:0] d);
    push_rx(W);
    push_rx(a);
    push_rx(d);
`ifdef RS232_CMD_CHKSUM_EN
    push_rx(W ^ a ^ d);
`endif
    wrq.push_back({a, d});
    txq.push_back(8'h4B);
    latq.push_back(3);
  endtask

  task automatic send_read(input logic [7:0] a, input logic [7:0] rdata);
    reg_rdata = rdata;
    push_rx(R);
    push_rx(a);
`ifdef RS232_CMD_CHKSUM_EN
    push_rx(R ^ a);
`endif
    rdq.push_back(a);
    txq.push_back(rdata);
    latq.push_back(4);
  endtask

  task automatic send_bad(input logic [7:0] c);
    push_rx(c);
    txq.push_back(8'h45);
    latq.push_back(2);
    if (exp_err < 255) exp_err++;
  endtask

  // Wait until every queued expectation has been consumed and the DUT is idle.
  task automatic wait_done(input string tag, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (txq.size() == 0 && wrq.size() == 0 && rdq.size() == 0 && !busy && rx_fifo_empty) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_done"}, ok, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    tx_fifo_full = 1'b0;
    reg_rdata    = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_strobes", {rx_fifo_rd_en, tx_fifo_wr_en, reg_wr_en, reg_rd_en}, 4'b0);
    check("rst_tx_data", tx_fifo_data, 8'h00);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_err_cnt", err_cnt, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Basic write and read.
    send_write(8'h10, 8'hA5);
    wait_done("write1", 100);
    send_read(8'h22, 8'h3C);
    wait_done("read1", 100);
    send_write(8'hFF, 8'h00);
    send_read(8'h00, 8'hC3);
    wait_done("wr_rd_b2b", 200);

    // Bad command.
    send_bad(8'h41);
    wait_done("bad_cmd", 100);
    check("err_cnt_1", err_cnt, exp_err);

`ifdef RS232_CMD_CHKSUM_EN
    // Corrupt checksum: error response and no register access.
    push_rx(W);
    push_rx(8'h10);
    push_rx(8'hA5);
    push_rx(8'h00);
    txq.push_back(8'h45);
    latq.push_back(2);
    exp_err++;
    wait_done("bad_chk", 100);
    check("err_cnt_chk", err_cnt, exp_err);
`endif

    // Timeout after a lone command byte.
    push_rx(W);
    txq.push_back(8'h45);
    latq.push_back(-1);
    exp_err++;
    repeat (200) @(posedge clk);
    #2;
    check("to_busy_early", busy, 1);
    check("to_no_resp_early", txq.size(), 1);
    wait_done("timeout", TimeoutCycles + 50);
    check("err_cnt_to", err_cnt, exp_err);
    send_write(8'h33, 8'h5A);
    wait_done("after_to", 100);

    // TX FIFO full stalls the response.
    tx_fifo_full = 1'b1;
    send_write(8'h44, 8'h99);
    latq.pop_back();
    latq.push_back(-1);
    repeat (100) @(posedge clk);
    #2;
    check("full_no_tx", txq.size(), 1);
    check("full_busy", busy, 1);
    check("full_wr_done", wrq.size(), 0);
    tx_fifo_full = 1'b0;
    wait_done("full", 50);

    // Error counter saturation.
    for (int i = 0; i < 256; i++) send_bad(8'h41);
    wait_done("sat", 3000);
    check("err_cnt_sat", err_cnt, 8'hFF);

    // Reset mid-frame: partial frame discarded, no strobes, no response.
    push_rx(W);
    push_rx(8'h10);
    for (int i = 0; i < 20 && !rx_fifo_empty; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobes", {rx_fifo_rd_en, tx_fifo_wr_en, reg_wr_en, reg_rd_en}, 4'b0);
    check("mid_rst_tx_data", tx_fifo_data, 8'h00);
    check("mid_rst_addr", reg_addr, 8'h00);
    check("mid_rst_wdata", reg_wdata, 8'h00);
    check("mid_rst_err_cnt", err_cnt, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("post_rst_idle", busy, 0);
    send_read(8'h7E, 8'h81);
    wait_done("post_rst", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
